seq_mult_rv: RTL and testbench

Parameterised iterative multiplier with valid/ready handshakes on its input and output. It is the successor to the fixed 16-bit, 1-bit-per-cycle signed multiplier. Width, bits retired per cycle and signed/unsigned mode are now selectable. It sits between an operand producer and a result consumer, and either side may stall.

---
 rtl/seq_mult_rv.sv | 116 +++++++++++
 tb/tb_seq_mult_rv.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_rv.sv
// seq_mult_rv: iterative signed/unsigned multiplier with valid/ready handshakes.
// Retires BPC multiplier bits per cycle; a WIDTH-bit multiply takes WIDTH/BPC
// calc cycles. The multiplicand is sign- or zero-extended to 2*WIDTH at accept
// time. In signed mode the multiplier's top bit carries negative weight, so the
// partial product for that bit is subtracted on the final calc cycle.
module seq_mult_rv #(
  parameter int WIDTH = 16,
  parameter int BPC   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               busy
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = $clog2(N) + 1;
  localparam int PW = 2 * WIDTH;

  generate
    if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_params
      $error("seq_mult_rv: WIDTH must be >= 2 and divisible by BPC");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   a_sh;
  logic [PW-1:0]   pp;
  logic [WIDTH-1:0] b_sh;
  logic            sgn;
  logic [CW-1:0]   cnt;
  logic            last;

  assign last = (cnt == CW'(N - 1));

  // Partial product for the BPC multiplier bits currently at the bottom of b_sh.
  always_comb begin
    pp = '0;
    for (int j = 0; j < BPC; j++) begin
      if (b_sh[j]) begin
        if (sgn && last && (j == BPC - 1))
          pp = pp - (a_sh << j);
        else
          pp = pp + (a_sh << j);
      end
    end
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      out_product <= '0;
      cnt         <= '0;
      acc         <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      sgn         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= in_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a}
                                  : {{WIDTH{1'b0}}, in_a};
            b_sh     <= in_b;
            sgn      <= in_signed;
            acc      <= '0;
            cnt      <= '0;
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          acc  <= acc + pp;
          a_sh <= a_sh << BPC;
          b_sh <= b_sh >> BPC;
          cnt  <= cnt + 1'b1;
          if (last) begin
            out_product <= acc + pp;
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_rv.sv
// Testbench for seq_mult_rv: directed vectors on a 16x16/BPC=1 instance and
// reference-model checks on a 32x32/BPC=4 instance.
module tb_seq_mult_rv;

  logic clk;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;

  // 16-bit, 1 bit per cycle
  logic        s_in_valid, s_in_ready, s_in_signed, s_out_valid, s_out_ready, s_busy;
  logic [15:0] s_in_a, s_in_b;
  logic [31:0] s_out_product;

  // 32-bit, 4 bits per cycle
  logic        w_in_valid, w_in_ready, w_in_signed, w_out_valid, w_out_ready, w_busy;
  logic [31:0] w_in_a, w_in_b;
  logic [63:0] w_out_product;

  seq_mult_rv #(.WIDTH(16), .BPC(1)) u_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_signed(s_in_signed),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_product(s_out_product), .busy(s_busy)
  );

  seq_mult_rv #(.WIDTH(32), .BPC(4)) u_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_a(w_in_a), .in_b(w_in_b), .in_signed(w_in_signed),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_product(w_out_product), .busy(w_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running cycle count used for latency and issue-period measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation on the 16-bit instance with out_ready held high.
  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic sg, input logic [31:0] exp);
    int n;
    int t_acc;
    n = 0;
    while (!s_in_ready && n < 50) begin tick(); n++; end
    check_val({tag, "_rdy"}, 64'(s_in_ready), 64'd1);
    s_in_a = a; s_in_b = b; s_in_signed = sg; s_in_valid = 1'b1; s_out_ready = 1'b1;
    tick();
    t_acc = cyc;
    s_in_valid = 1'b0;
    s_in_a = 16'h5A5A; s_in_b = 16'hA5A5; s_in_signed = ~sg;
    n = 0;
    while (!s_out_valid && n < 50) begin tick(); n++; end
    check_val({tag, "_lat"}, 64'(cyc - t_acc), 64'd16);
    check_val({tag, "_prod"}, 64'(s_out_product), 64'(exp));
    tick();
    check_val({tag, "_ovld_drop"}, 64'(s_out_valid), 64'd0);
    check_val({tag, "_hold"}, 64'(s_out_product), 64'(exp));
  endtask

  initial begin
    int n;
    int t_acc;
    int t_prev;
    logic [31:0] ra, rb;
    logic        rs;
    logic [63:0] rexp;

    cyc = 0; n_tests = 0; n_fail = 0;
    s_in_valid = 0; s_in_a = 0; s_in_b = 0; s_in_signed = 0; s_out_ready = 0;
    w_in_valid = 0; w_in_a = 0; w_in_b = 0; w_in_signed = 0; w_out_ready = 0;
    rst = 1'b1;
    repeat (3) tick();
    check_val("rst_in_ready", 64'(s_in_ready), 64'd1);
    check_val("rst_out_valid", 64'(s_out_valid), 64'd0);
    check_val("rst_busy", 64'(s_busy), 64'd0);
    check_val("rst_product", 64'(s_out_product), 64'd0);
    rst = 1'b0;
    tick();

    run16("neg3x5", 16'hFFFD, 16'h0005, 1'b1, 32'hFFFF_FFF1);
    run16("ffff_uns", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
    run16("ffff_sgn", 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001);
    run16("min_min", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
    run16("min_max", 16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000);
    run16("zero", 16'h0000, 16'h1234, 1'b0, 32'h0000_0000);
    run16("min_x1_uns", 16'h8000, 16'h0002, 1'b0, 32'h0001_0000);

    // Backpressure: result held while consumer stalls, new operands ignored.
    s_in_a = 16'd3; s_in_b = 16'd4; s_in_signed = 1'b0; s_in_valid = 1'b1; s_out_ready = 1'b0;
    tick();
    s_in_a = 16'd9; s_in_b = 16'd9;
    n = 0;
    while (!s_out_valid && n < 50) begin tick(); n++; end
    check_val("bp_first", 64'(s_out_product), 64'd12);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_out_product !== 32'd12 || s_in_ready !== 1'b0 || s_out_valid !== 1'b1 || s_busy !== 1'b1)
        check_val("bp_stall", {s_out_product, 29'd0, s_in_ready, s_out_valid, s_busy},
                  {32'd12, 29'd0, 1'b0, 1'b1, 1'b1});
    end
    check_val("bp_stall_end", {s_out_product, 29'd0, s_in_ready, s_out_valid, s_busy},
              {32'd12, 29'd0, 1'b0, 1'b1, 1'b1});
    s_out_ready = 1'b1;
    tick();
    check_val("bp_release_ovld", 64'(s_out_valid), 64'd0);
    check_val("bp_release_rdy", 64'(s_in_ready), 64'd1);
    tick();
    check_val("bp_next_accept", 64'(s_busy), 64'd1);
    s_in_valid = 1'b0;
    n = 0;
    while (!s_out_valid && n < 50) begin tick(); n++; end
    check_val("bp_next_prod", 64'(s_out_product), 64'd81);
    tick();

    // Reset partway through a calculation aborts it.
    s_in_a = 16'd100; s_in_b = 16'd100; s_in_signed = 1'b0; s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    repeat (6) tick();
    check_val("abort_busy_pre", 64'(s_busy), 64'd1);
    rst = 1'b1;
    #1;
    check_val("abort_in_ready", 64'(s_in_ready), 64'd1);
    check_val("abort_out_valid", 64'(s_out_valid), 64'd0);
    check_val("abort_product", 64'(s_out_product), 64'd0);
    tick();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_out_valid) n++;
    end
    check_val("abort_no_output", 64'(n), 64'd0);
    run16("post_abort_7x9", 16'd7, 16'd9, 1'b0, 32'd63);

    // 32-bit, BPC=4: reference model, latency 8, back-to-back period 10.
    w_out_ready = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      if (i == 0) begin ra = 32'h8000_0000; rb = 32'h8000_0000; rs = 1'b1; end
      if (i == 1) begin ra = 32'hFFFF_FFFF; rb = 32'hFFFF_FFFF; rs = 1'b0; end
      rexp = rs ? ({{32{ra[31]}}, ra} * {{32{rb[31]}}, rb}) : ({32'd0, ra} * {32'd0, rb});
      w_in_a = ra; w_in_b = rb; w_in_signed = rs; w_in_valid = 1'b1;
      n = 0;
      while (!w_in_ready && n < 50) begin tick(); n++; end
      tick();
      t_acc = cyc;
      if (i > 0) check_val("w_period", 64'(t_acc - t_prev), 64'd10);
      t_prev = t_acc;
      n = 0;
      while (!w_out_valid && n < 50) begin tick(); n++; end
      check_val("w_lat", 64'(cyc - t_acc), 64'd8);
      check_val("w_prod", w_out_product, rexp);
    end
    w_in_valid = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
